// File: rtl/bw_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bw_mult_pkg
// Brief    : Shared definitions for the sequential Baugh-Wooley multiplier:
//            FSM state encoding and the correction constant K.
// Revision : 1.0 - initial release
// ============================================================================
package bw_mult_pkg;

    // FSM state encoding shared by the multiplier top level
    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Baugh-Wooley correction constant. Returned 64 bits wide; the caller
    // keeps the low A_W+B_W bits, which realises the modulo 2^(A_W+B_W).
    // Unsigned operation needs no correction, so K is zero.
    function automatic logic [63:0] bw_k_const(input int a_w, input int b_w,
                                               input logic sgn);
        logic [63:0] k;
        k = '0;
        if (sgn) begin
            k = (64'd1 << (a_w - 1)) + (64'd1 << (b_w - 1))
              + (64'd1 << (a_w + b_w - 1));
        end
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bw_row_gen.sv
`default_nettype none
// ============================================================================
// Module   : bw_row_gen
// Brief    : Combinational Baugh-Wooley partial-product row generator. ANDs
//            the multiplicand with one multiplier bit and inverts the cross
//            sign terms (exactly one operand's sign bit involved) in signed
//            mode.
// Revision : 1.0 - initial release
// ============================================================================
module bw_row_gen #(
    parameter int A_W = 7
) (
    input  logic [A_W-1:0] a,
    input  logic           b_bit,
    input  logic           is_last_row,
    input  logic           sgn,
    output logic [A_W-1:0] row
);

    // On the last row every non-sign bit of a meets b's sign bit; on other
    // rows only a's sign bit is a cross term. a_msb x b_msb stays positive.
    wire w_inv_low = sgn & is_last_row;
    wire w_inv_msb = sgn & ~is_last_row;

    genvar j;
    generate
        for (j = 0; j < A_W; j++) begin : g_bit
            if (j == A_W - 1) begin : g_msb
                assign row[j] = (a[j] & b_bit) ^ w_inv_msb;
            end else begin : g_low
                assign row[j] = (a[j] & b_bit) ^ w_inv_low;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bw_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : bw_seq_mult
// Brief    : Sequential Baugh-Wooley multiplier, one partial-product row per
//            clock, signed or unsigned, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bw_seq_mult
    import bw_mult_pkg::*;
#(
    parameter int A_W = 7,
    parameter int B_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [A_W+B_W-1:0] p
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

    localparam logic [CNT_W-1:0] c_last_row   = CNT_W'(B_W - 1);
    localparam logic [63:0]      c_k_full     = bw_k_const(A_W, B_W, 1'b1);
    localparam logic [P_W-1:0]   c_k_signed   = c_k_full[P_W-1:0];

    logic [c_ST_W-1:0] r_state_q, w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [A_W-1:0]    r_a_q,     w_a_d;
    logic [B_W-1:0]    r_b_q,     w_b_d;
    logic              r_sgn_q,   w_sgn_d;
    logic [P_W-1:0]    r_acc_q,   w_acc_d;
    logic [P_W-1:0]    r_p_q,     w_p_d;
    logic              r_busy_q,  w_busy_d;
    logic              r_done_q,  w_done_d;

    logic              w_last_row;
    logic [A_W-1:0]    w_row;
    logic [P_W-1:0]    w_row_shifted;
    logic [P_W-1:0]    w_sum;

    assign w_last_row    = (r_cnt_q == c_last_row);
    assign w_row_shifted = {{B_W{1'b0}}, w_row} << r_cnt_q;
    // Carries out of the MSB fall off here: the sum is modulo 2^P_W.
    assign w_sum         = r_acc_q + w_row_shifted;

    bw_row_gen #(
        .A_W (A_W)
    ) u_row_gen (
        .a           (r_a_q),
        .b_bit       (r_b_q[r_cnt_q]),
        .is_last_row (w_last_row),
        .sgn         (r_sgn_q),
        .row         (w_row)
    );

    // Next-state logic: accept in IDLE, accumulate one row per RUN cycle,
    // publish the product when the last row is added.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_sgn_d   = r_sgn_q;
        w_acc_d   = r_acc_q;
        w_p_d     = r_p_q;
        case (r_state_q)
            c_st_idle: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_sgn_d   = sgn;
                    w_acc_d   = sgn ? c_k_signed : '0;
                    w_cnt_d   = '0;
                    w_state_d = c_st_run;
                end
            end
            c_st_run: begin
                w_acc_d = w_sum;
                w_cnt_d = r_cnt_q + 1'b1;
                if (w_last_row) begin
                    w_p_d     = w_sum;
                    w_cnt_d   = '0;
                    w_state_d = c_st_done;
                end
            end
            c_st_done: begin
                w_state_d = c_st_idle;
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase
        w_busy_d = (w_state_d == c_st_run);
        w_done_d = (w_state_d == c_st_done);
    end

    // State, datapath and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_st_idle;
            r_cnt_q   <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sgn_q   <= 1'b0;
            r_acc_q   <= '0;
            r_p_q     <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sgn_q   <= w_sgn_d;
            r_acc_q   <= w_acc_d;
            r_p_q     <= w_p_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign p    = r_p_q;

endmodule
`default_nettype wire

// File: tb/tb_bw_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_bw_seq_mult
// Brief    : Self-checking bench for bw_seq_mult (7x5 and 8x8 instances)
//            against a behavioural reference multiply.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bw_seq_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start0 = 1'b0, sgn0 = 1'b0;
    logic [6:0]  a0 = '0;
    logic [4:0]  b0 = '0;
    logic        busy0, done0;
    logic [11:0] p0;

    logic        start1 = 1'b0, sgn1 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [7:0]  b1 = '0;
    logic        busy1, done1;
    logic [15:0] p1;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    bw_seq_mult #(.A_W(7), .B_W(5)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .sgn(sgn0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .p(p0)
    );

    bw_seq_mult #(.A_W(8), .B_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sgn(sgn1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .p(p1)
    );

    // Reference product: plain integer multiply, truncated to aw+bw bits.
    function automatic longint ref_prod(int aw, int bw, longint a, longint b, bit s);
        longint x, y;
        x = a;
        y = b;
        if (s) begin
            if (x[aw-1]) x = x - (longint'(1) << aw);
            if (y[bw-1]) y = y - (longint'(1) << bw);
        end
        return (x * y) & ((longint'(1) << (aw + bw)) - 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: timing as seen at the ports, result from ref_prod.
    int     m0_phase = 0, m0_rem = 0, m1_phase = 0, m1_rem = 0;
    longint m0_prod = 0, m1_prod = 0;
    logic   m0_busy = 0, m0_done = 0, m1_busy = 0, m1_done = 0;
    logic [11:0] m0_p = '0;
    logic [15:0] m1_p = '0;

    always @(posedge clk) begin
        if (rst) begin
            m0_phase = 0; m0_busy = 0; m0_done = 0; m0_p = '0;
            m1_phase = 0; m1_busy = 0; m1_done = 0; m1_p = '0;
        end else begin
            case (m0_phase)
                0: if (start0) begin
                    m0_prod = ref_prod(7, 5, a0, b0, sgn0);
                    m0_rem = 5; m0_phase = 1; m0_busy = 1;
                end
                1: begin
                    m0_rem--;
                    if (m0_rem == 0) begin
                        m0_phase = 2; m0_busy = 0; m0_done = 1; m0_p = 12'(m0_prod);
                    end
                end
                default: begin m0_phase = 0; m0_done = 0; end
            endcase
            case (m1_phase)
                0: if (start1) begin
                    m1_prod = ref_prod(8, 8, a1, b1, sgn1);
                    m1_rem = 8; m1_phase = 1; m1_busy = 1;
                end
                1: begin
                    m1_rem--;
                    if (m1_rem == 0) begin
                        m1_phase = 2; m1_busy = 0; m1_done = 1; m1_p = 16'(m1_prod);
                    end
                end
                default: begin m1_phase = 0; m1_done = 0; end
            endcase
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy0", 64'(busy0), 64'(m0_busy));
            chk("done0", 64'(done0), 64'(m0_done));
            chk("p0",    64'(p0),    64'(m0_p));
            chk("busy1", 64'(busy1), 64'(m1_busy));
            chk("done1", 64'(done1), 64'(m1_done));
            chk("p1",    64'(p1),    64'(m1_p));
        end
    end

    task automatic run_op(input string nm, input logic [6:0] a, input logic [4:0] b,
                          input logic s, input logic [11:0] exp);
        int lat;
        @(negedge clk);
        a0 = a; b0 = b; sgn0 = s; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; a0 = ~a; b0 = ~b; sgn0 = ~s;
        lat = 1;
        while (!done0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd6);
        chk({nm, "_p"}, 64'(p0), 64'(exp));
    endtask

    task automatic sweep0();
        int mul, off, n, ndone;
        logic [12:0] idx;
        mul = int'(($urandom | 1) & 8191);
        off = int'($urandom & 8191);
        n = 0;
        while (n < 8192) begin
            @(negedge clk);
            start0 = 1'b1;
            if (m0_phase == 0) begin
                idx = 13'(n * mul + off);
                {sgn0, a0, b0} = idx;
                n++;
            end else begin
                a0 = 7'($urandom); b0 = 5'($urandom); sgn0 = 1'($urandom);
            end
        end
        @(negedge clk);
        start0 = 1'b0;
        ndone = 0;
        while (m0_phase != 0 && ndone < 20) begin
            @(negedge clk);
            ndone++;
        end
    endtask

    task automatic sweep1();
        int n, w;
        n = 0;
        while (n < 2500) begin
            @(negedge clk);
            start1 = 1'b1;
            a1 = 8'($urandom); b1 = 8'($urandom); sgn1 = 1'($urandom);
            if (m1_phase == 0) n++;
        end
        @(negedge clk);
        start1 = 1'b0;
        w = 0;
        while (m1_phase != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Directed scenarios, then both random sweeps in parallel.
    initial begin
        int cnt;

        chk("pin_neg_neg",   ref_prod(7, 5, 'h40, 'h10, 1'b1), 64'h400);
        chk("pin_neg_pos",   ref_prod(7, 5, 'h40, 'h0F, 1'b1), 64'hC40);
        chk("pin_pos_neg",   ref_prod(7, 5, 'h3F, 'h10, 1'b1), 64'hC10);
        chk("pin_uns_max",   ref_prod(7, 5, 'h7F, 'h1F, 1'b0), 64'hF61);
        chk("pin_sgn_m1m1",  ref_prod(7, 5, 'h7F, 'h1F, 1'b1), 64'h001);
        chk("pin8_neg_neg",  ref_prod(8, 8, 'h80, 'h80, 1'b1), 64'h4000);
        chk("pin8_uns_max",  ref_prod(8, 8, 'hFF, 'hFF, 1'b0), 64'hFE01);

        repeat (3) @(negedge clk);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_p0",    64'(p0),    64'd0);
        chk("rst_p1",    64'(p1),    64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        run_op("ss_m64_m16", 7'h40, 5'h10, 1'b1, 12'h400);
        run_op("ss_m64_p15", 7'h40, 5'h0F, 1'b1, 12'hC40);
        run_op("ss_p63_m16", 7'h3F, 5'h10, 1'b1, 12'hC10);
        run_op("uu_max",     7'h7F, 5'h1F, 1'b0, 12'hF61);
        run_op("ss_m1_m1",   7'h7F, 5'h1F, 1'b1, 12'h001);

        // Start held high: one accept per 7 cycles, DONE-cycle starts ignored.
        cnt = 0;
        for (int k = 0; k < 70; k++) begin
            if (k > 0 && done0) cnt++;
            start0 = 1'b1;
            a0 = 7'($urandom); b0 = 5'($urandom); sgn0 = 1'($urandom);
            @(negedge clk);
        end
        if (done0) cnt++;
        start0 = 1'b0;
        chk("hold_start_done_count", 64'(cnt), 64'd10);
        repeat (2) @(negedge clk);

        // Reset during the third RUN cycle drops the operation silently.
        a0 = 7'h40; b0 = 5'h10; sgn0 = 1'b1; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrun_rst_busy", 64'(busy0), 64'd0);
        chk("midrun_rst_done", 64'(done0), 64'd0);
        chk("midrun_rst_p",    64'(p0),    64'd0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0) cnt++;
        end
        chk("midrun_rst_no_done", 64'(cnt), 64'd0);
        run_op("after_rst", 7'h15, 5'h0B, 1'b0, 12'h0E7);

        fork
            sweep0();
            sweep1();
        join

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
